tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter BLOCK_NAME, default "tdm_demux", hierarchical block name for diagrams.
REQ-002 SHALL have parameters X, Y, DX, DY, default 0, diagram position and extent.
REQ-003 SHALL have parameter ARCHITECTURE, default "BEHAVIORAL"; only "BEHAVIORAL" is implemented, and "VIRTEX5"/"VIRTEX6" SHALL elaborate to the same behaviour.
REQ-004 SHALL have parameter SELECT_LINES, default 8, giving a frame length N = 2**SELECT_LINES bits.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in  input  1  serial data bit.
REQ-008 in_valid  input  1  in is sampled this cycle.
REQ-009 sync  input  1  qualified by in_valid; the current bit is frame index 0.
REQ-010 out  output  N  assembled frame; bit k = k-th sampled bit after sync.
REQ-011 out_valid  output  1  out holds an unaccepted frame.
REQ-012 out_ready  input  1  consumer accepts out this cycle when out_valid=1.
REQ-013 sync_err  output  1  one-cycle pulse when a frame is resynchronised early.
REQ-014 overflow  output  1  sticky; a completed frame was dropped.
REQ-015 err_count  output  16  error event count (see Configuration).

Function
REQ-016 SHALL implement states IDLE (discard input until sync) and FILL (assemble frames).
REQ-017 IDLE: in_valid=1 and sync=0 SHALL be ignored; in_valid=1 and sync=1 SHALL write in to buffer index 0, set index to 1, and go to FILL.
REQ-018 FILL: in_valid=1 and sync=0 SHALL write in to buffer[index], then increment index modulo N; in_valid=0 SHALL hold all state.
REQ-019 FILL: in_valid=1 and sync=1 with index!=0 SHALL discard the partial frame, write the bit at index 0, set index to 1, and pulse sync_err the next cycle.
REQ-020 FILL: sync=1 at index 0 SHALL be legal and SHALL NOT pulse sync_err.
REQ-021 On writing index N-1, the complete frame (including that bit) SHALL load into out with out_valid=1 on the next cycle (latency 1), provided the slot is free.
REQ-022 The slot is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle (back-to-back transfer, out_valid stays 1).
REQ-023 If the slot is not free at completion, the new frame SHALL be dropped, out SHALL keep the old frame, and overflow SHALL set.
REQ-024 out SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 An accept with no simultaneous completion SHALL clear out_valid on the next cycle.
REQ-026 After index N-1, the block SHALL stay in FILL with index 0 (continuous framing); it does not need a new sync.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, index 0, buffer 0, out 0, out_valid 0, sync_err 0, overflow 0, and err_count 0, including mid-frame.
REQ-029 Deassertion SHALL take effect on the first rising clk edge with rst_n high; no input is sampled while rst_n is low.
REQ-030 overflow SHALL clear only on reset.

Configuration
REQ-031 Macro TDM_DEMUX_ERR_COUNT_EN defined: err_count SHALL increment by 1 per sync_err pulse or overflow event, and SHALL increment by 2 if both occur in the same cycle.
REQ-032 err_count SHALL saturate at 16'hFFFF.
REQ-033 Macro undefined: err_count SHALL be constant 0 and SHALL have no counter logic; all other behaviour SHALL be unchanged.

Verification (SELECT_LINES=3, N=8)
REQ-034 Reset, then stream 8 valid bits 1,0,1,1,0,0,1,0 with sync on the first bit and out_ready=1: out=8'b01001101, out_valid pulses 1 cycle after the 8th bit.
REQ-035 In IDLE, 5 valid bits without sync, then a synced frame: out reflects only the synced frame.
REQ-036 Hold out_ready=0 across two complete frames A then B: out=A held, overflow=1, err_count=1 (macro on) or 0 (macro off); raising out_ready delivers A.
REQ-037 Assert sync on bit 4 of a frame: sync_err pulses once, and the next out is the 8 bits starting at the resync bit.
REQ-038 Pull rst_n low after 5 bits, release, then send a synced frame: all outputs 0 during reset, and the next out is the new frame only.
REQ-039 Continuous 3 frames with in_valid gaps and out_ready=1: 3 out_valid pulses with correct data, no sync_err.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: serial TDM bit-stream to parallel frame demultiplexer.
//
// Serial bits, qualified by in_valid, are assembled into an N = 2**SELECT_LINES
// bit frame. Bit k of the frame is the k-th sampled bit after sync. A sync that
// arrives mid-frame discards the partial frame. The block keeps framing
// continuously after the first sync. A completed frame is presented on out
// with a valid/ready handshake. A frame that completes while the output slot
// is still occupied is dropped, and the sticky overflow flag is set.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         serial data bit
//   in_valid   in (and sync) are sampled this cycle
//   sync       current bit is frame index 0
//   out        assembled frame (N bits)
//   out_valid  out holds an unaccepted frame
//   out_ready  consumer accepts out this cycle
//   sync_err   one-cycle pulse after an early resynchronisation
//   overflow   sticky, a completed frame was dropped
//   err_count  saturating error count
//
// Optional feature: define TDM_DEMUX_ERR_COUNT_EN to build the error counter.
// Without that define, err_count is tied to zero.
module tdm_demux #(
  parameter string BLOCK_NAME   = "tdm_demux",
  parameter int    X            = 0,
  parameter int    Y            = 0,
  parameter int    DX           = 0,
  parameter int    DY           = 0,
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    SELECT_LINES = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       sync,
  output logic [2**SELECT_LINES-1:0] out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       sync_err,
  output logic                       overflow,
  output logic [15:0]                err_count
);

  localparam int N = 2**SELECT_LINES;

  // All architecture variants share the behavioural implementation. The
  // diagram parameters carry no logic; they are only sanity-checked here.
  if (ARCHITECTURE != "BEHAVIORAL" && ARCHITECTURE != "VIRTEX5" &&
      ARCHITECTURE != "VIRTEX6") begin : g_bad_arch
    $error("tdm_demux: unsupported ARCHITECTURE");
  end
  if (SELECT_LINES < 1 || X < 0 || Y < 0 || DX < 0 || DY < 0 ||
      BLOCK_NAME == "") begin : g_bad_param
    $error("tdm_demux: invalid parameter value");
  end

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  state_q, state_d;
  logic [SELECT_LINES-1:0] idx_q, idx_d;
  logic [N-1:0]            buf_q, buf_d;
  logic [N-1:0]            out_q, out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    sync_err_q, sync_err_d;
  logic                    overflow_q, overflow_d;
  logic                    complete;
  logic                    drop;
  logic [N-1:0]            frame;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    sync_err_d  = 1'b0;
    complete    = 1'b0;
    drop        = 1'b0;
    frame       = buf_q;
    frame[idx_q] = in;

    if (in_valid) begin
      if (sync) begin
        // A sync at index 0 is legal. At any other index, it aborts the partial frame.
        buf_d      = '0;
        buf_d[0]   = in;
        idx_d      = SELECT_LINES'(1);
        state_d    = FILL;
        sync_err_d = (state_q == FILL) && (idx_q != '0);
      end else if (state_q == FILL) begin
        buf_d    = frame;
        idx_d    = idx_q + SELECT_LINES'(1);
        complete = (idx_q == '1);
      end
    end

    // An accept clears the slot. A completion in the same cycle refills it,
    // so out_valid stays high for back-to-back frames.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_d       = frame;
        out_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      buf_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign overflow  = overflow_q;

`ifdef TDM_DEMUX_ERR_COUNT_EN
  logic [15:0] err_count_q, err_count_d;
  logic [16:0] err_sum;

  // Count each visible sync_err pulse and each dropped frame. Both can count
  // in one cycle. The count saturates at all-ones.
  always_comb begin
    err_sum     = {1'b0, err_count_q} + 17'(sync_err_q) + 17'(drop);
    err_count_d = err_sum[16] ? '1 : err_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

`ifdef TDM_DEMUX_ERR_COUNT_EN
  localparam int EC = 1;
`else
  localparam int EC = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        din;
  logic        in_valid;
  logic        sync;
  logic [7:0]  out;
  logic        out_valid;
  logic        out_ready;
  logic        sync_err;
  logic        overflow;
  logic [15:0] err_count;

  int checks   = 0;
  int failures = 0;

  tdm_demux #(.SELECT_LINES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (din),
    .in_valid  (in_valid),
    .sync      (sync),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sync_err  (sync_err),
    .overflow  (overflow),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv, sy, d, rdy;
    logic       ov;
    logic [7:0] dout;
    logic       se, of;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic iv, input logic sy, input logic d, input logic rdy);
    in_valid  = iv;
    sync      = sy;
    din       = d;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic iv, input logic sy, input logic d, input logic rdy,
                     input logic ov, input logic [7:0] dout, input logic se, input logic of);
    vec_t v;
    v.iv = iv; v.sy = sy; v.d = d; v.rdy = rdy;
    v.ov = ov; v.dout = dout; v.se = se; v.of = of;
    vecs.push_back(v);
  endtask

  // One frame of 8 bits, LSB first, with out_ready=1. An optional idle cycle is inserted before bit gap_at.
  // Expected: out_valid only after the last bit. out keeps prev until then.
  task automatic add_frame(input logic [7:0] f, input logic sy, input int gap_at,
                           input logic [7:0] prev);
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, prev, 1'b0, 1'b0);
      add(1'b1, sy && (k == 0), f[k], 1'b1, k == 7, (k == 7) ? f : prev, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] f, input logic sy, input logic rdy_body,
                            input logic rdy_last);
    for (int k = 0; k < 8; k++)
      step(1'b1, sy && (k == 0), f[k], (k == 7) ? rdy_last : rdy_body);
  endtask

  initial begin
    // Idle bits before any sync must be ignored (no sync_err, no frame).
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    add_frame(8'h96, 1'b1, 8, 8'h00);
    // Bits 1,0,1,1,0,0,1,0 give out=8'b01001101. Sync at index 0 is legal.
    add_frame(8'h4D, 1'b1, 8, 8'h96);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
    // Resync on bit 4. The next frame starts at the resync bit (0,1,0,1,1,0,0,1).
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h9A, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h9A, 1'b0, 1'b0);
    // Three continuous frames with in_valid gaps and no further sync.
    add_frame(8'hA5, 1'b1, 3, 8'h9A);
    add_frame(8'h3C, 1'b0, 5, 8'hA5);
    add_frame(8'hE7, 1'b0, 1, 8'h3C);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE7, 1'b0, 1'b0);

    rst_n = 1'b0;
    in_valid = 1'b0; sync = 1'b0; din = 1'b0; out_ready = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_sync_err", 32'(sync_err), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].sy, vecs[i].d, vecs[i].rdy);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].dout));
      chk($sformatf("vec%0d_sync_err", i), 32'(sync_err), 32'(vecs[i].se));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].of));
    end
    chk("tbl_err_count", 32'(err_count), 32'(EC));

    // Overflow: frame A held, frame B dropped, then A delivered.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("ovf_a_valid", 32'(out_valid), 32'h1);
    chk("ovf_a_out", 32'(out), 32'h5A);
    chk("ovf_a_flag", 32'(overflow), 32'h0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    chk("ovf_b_valid", 32'(out_valid), 32'h1);
    chk("ovf_b_out", 32'(out), 32'h5A);
    chk("ovf_b_flag", 32'(overflow), 32'h1);
    chk("ovf_b_err", 32'(err_count), 32'(2 * EC));
    chk("ovf_b_se", 32'(sync_err), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_acc_valid", 32'(out_valid), 32'h0);
    chk("ovf_acc_out", 32'(out), 32'h5A);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // Back-to-back: the accept and the completion happen in the same cycle.
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    chk("b2b_c_out", 32'(out), 32'h0F);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
    chk("b2b_d_valid", 32'(out_valid), 32'h1);
    chk("b2b_d_out", 32'(out), 32'hF0);
    chk("b2b_err", 32'(err_count), 32'(2 * EC));
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_drain", 32'(out_valid), 32'h0);

    // A resync is counted when its sync_err pulse appears.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("resync_se", 32'(sync_err), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("resync_se_end", 32'(sync_err), 32'h0);
    chk("resync_err", 32'(err_count), 32'(3 * EC));

    // An asynchronous reset mid-frame clears all outputs at once.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'h0);
    chk("arst_overflow", 32'(overflow), 32'h0);
    chk("arst_err", 32'(err_count), 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("arst_hold_out", 32'(out), 32'h0);
    chk("arst_hold_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h69, 1'b1, 1'b1, 1'b1);
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    chk("post_rst_out", 32'(out), 32'h69);
    chk("post_rst_se", 32'(sync_err), 32'h0);
    chk("post_rst_err", 32'(err_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
